// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and shared constants for the RV32M multiply/divide unit.
package muldiv_pkg;
  localparam int ITER = 32;
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
endpackage

// File: rtl/muldiv_divider.sv
// muldiv_divider: unsigned restoring divider; the first step runs on the start edge, ready after ITER steps.
module muldiv_divider
  import muldiv_pkg::*;
#(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o,
  output logic         ready_o
);
  logic [W-1:0] q_q, r_q, d_q, src_q, src_r, dv;
  logic [W:0]   sh, diff;
  logic [5:0]   cnt_q;
  logic         fits, run;
  always_comb begin
    run   = cnt_q != 6'd0 && cnt_q < 6'(ITER);
    src_q = start_i ? dividend_i : q_q;
    src_r = start_i ? '0 : r_q;
    dv    = start_i ? divisor_i : d_q;
    sh    = {src_r, src_q[W-1]};
    diff  = sh - {1'b0, dv};
    fits  = sh >= {1'b0, dv};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else if (start_i || run) begin
      cnt_q <= start_i ? 6'd1 : cnt_q + 6'd1;
      d_q   <= dv;
      r_q   <= fits ? diff[W-1:0] : sh[W-1:0];
      q_q   <= {src_q[W-2:0], fits};
    end
  assign quotient_o  = q_q;
  assign remainder_o = r_q;
  assign ready_o     = cnt_q == 6'(ITER);
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with register-file write-back outputs.
// MULDIV_FAST_MUL_EN selects a single-cycle multiply instead of the 32-step shift-add.
module muldiv_unit
  import muldiv_pkg::*;
#(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            wb_en,
  output logic [4:0]      wb_idx,
  output logic [XLEN-1:0] wb_data
);
  state_e state_q, state_d;
  logic [2:0]        op_q;
  logic [4:0]        rd_q, cnt_q;
  logic              neg_q, aneg_q;
  logic [XLEN-1:0]   mcand_q, wb_data_q, a_mag, b_mag, byp_data, dq, dr, quo, rem, mul_word, div_word;
  logic [2*XLEN-1:0] prod_q, prod_fin, mul_res;
  logic              a_sgn, b_sgn, a_neg, b_neg, is_div, div0, ovf, bypass, accept, mul_last, div_ready;
  always_comb begin
    a_sgn    = op != OP_MULHU && op != OP_DIVU && op != OP_REMU;
    b_sgn    = a_sgn && op != OP_MULHSU;
    a_neg    = a_sgn && a[XLEN-1];
    b_neg    = b_sgn && b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    is_div   = op[2];
    div0     = is_div && b == '0;
    ovf      = is_div && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    bypass   = div0 || ovf;
    byp_data = op[1] ? (div0 ? a : '0) : (div0 ? DIV_BY_ZERO_Q : 32'h8000_0000);
    accept   = state_q == S_IDLE && start && !flush;
  end
  muldiv_divider #(.W(XLEN)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (accept && is_div && !bypass),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quotient_o (dq),
    .remainder_o(dr),
    .ready_o    (div_ready)
  );
`ifdef MULDIV_FAST_MUL_EN
  always_comb begin
    prod_fin = {{XLEN{1'b0}}, mcand_q} * {{XLEN{1'b0}}, prod_q[XLEN-1:0]};
    mul_last = 1'b1;
  end
`else
  logic [XLEN:0] sum;
  // Shift-add step: add the multiplicand into the high half, then shift the whole product right.
  always_comb begin
    sum      = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_fin = {sum, prod_q[XLEN-1:1]};
    mul_last = cnt_q == 5'(ITER - 1);
  end
`endif
  always_comb begin
    mul_res  = neg_q ? -prod_fin : prod_fin;
    mul_word = op_q == OP_MUL ? mul_res[XLEN-1:0] : mul_res[2*XLEN-1:XLEN];
    quo      = neg_q ? -dq : dq;
    rem      = aneg_q ? -dr : dr;
    div_word = op_q[1] ? rem : quo;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = !start ? S_IDLE : bypass ? S_DONE : is_div ? S_DIV : S_MUL;
      S_MUL:   state_d = mul_last ? S_DONE : S_MUL;
      S_DIV:   state_d = div_ready ? S_DONE : S_DIV;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      aneg_q    <= 1'b0;
      mcand_q   <= '0;
      prod_q    <= '0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= op;
        rd_q    <= rd_in;
        cnt_q   <= '0;
        neg_q   <= a_neg ^ b_neg;
        aneg_q  <= a_neg;
        mcand_q <= a_mag;
        prod_q  <= {{XLEN{1'b0}}, b_mag};
        if (bypass) wb_data_q <= byp_data;
      end
      if (state_q == S_MUL && !flush) begin
        prod_q <= prod_fin;
        cnt_q  <= cnt_q + 5'd1;
        if (mul_last) wb_data_q <= mul_word;
      end
      if (state_q == S_DIV && div_ready && !flush) wb_data_q <= div_word;
    end
  assign busy    = state_q != S_IDLE;
  assign done    = state_q == S_DONE && !flush;
  assign wb_en   = done && wb_idx != 5'd0;
  assign wb_idx  = rd_q;
  assign wb_data = wb_data_q;
endmodule
